ss2b_scan: RTL and testbench

Seven-segment receiver/decoder, the inverse of the team's binary-to-seven-segment encoder. Samples a multiplexed segment/digit-select bus, such as an external display driver being monitored or a scan-chain tap. It waits for each digit pattern to hold stable, then decodes the 7-bit pattern back to the 5-bit symbol code and stores it per digit. Once every digit has been refreshed, it emits a one-cycle frame strobe. Used for display loopback checking and for reading legacy instruments with 7-segment outputs.

---
 rtl/ss2b_scan.sv | 161 ++++++++++++++++
 tb/tb_ss2b_scan.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss2b_scan.sv
// ss2b_scan: seven-segment scan receiver / decoder.
//
// Watches a multiplexed segment + digit-select bus, waits for each digit
// pattern to stay put for STABLE_CYC synchronised cycles, then decodes the
// 7-bit segment pattern back into a 5-bit symbol code for that digit.
// Once every digit has been captured, a one-cycle frame strobe is raised.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   seg_in[6:0]  segment lines a..g (bit0 = a), asynchronous to clk
//   dig_in       digit-select lines, one-hot when valid, asynchronous to clk
//   codes        decoded 5-bit code per digit, digit i at [5i+4:5i]
//   bad          per digit, 1 = last capture was an unrecognised pattern
//   frame_valid  one-cycle pulse once every digit has been captured
module ss2b_scan #(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYC     = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_in,
  output logic [5*DIGITS-1:0]   codes,
  output logic [DIGITS-1:0]     bad,
  output logic                  frame_valid
);

  localparam int SW = DIGITS + 7;

  logic [6:0]        seg_s1, seg_s2;
  logic [DIGITS-1:0] dig_s1, dig_s2;
  logic [6:0]        seg_cur;
  logic [DIGITS-1:0] dig_cur;
  logic [SW-1:0]     sample_cur;
  logic [SW-1:0]     sample_prev;
  logic [7:0]        run_cnt;
  logic              run_done;
  logic              capture;
  logic [DIGITS-1:0] dig_prev;
  logic [6:0]        seg_prev;
  logic [5:0]        dec;
  logic [DIGITS-1:0] seen;

  // Returns {bad, code}; unknown patterns map to code 31 with bad set.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'h3F: r = {1'b0, 5'd0};
      7'h06: r = {1'b0, 5'd1};
      7'h5B: r = {1'b0, 5'd2};
      7'h4F: r = {1'b0, 5'd3};
      7'h66: r = {1'b0, 5'd4};
      7'h6D: r = {1'b0, 5'd5};
      7'h7D: r = {1'b0, 5'd6};
      7'h07: r = {1'b0, 5'd7};
      7'h7F: r = {1'b0, 5'd8};
      7'h6F: r = {1'b0, 5'd9};
      7'h77: r = {1'b0, 5'd10};
      7'h7C: r = {1'b0, 5'd11};
      7'h39: r = {1'b0, 5'd12};
      7'h5E: r = {1'b0, 5'd13};
      7'h79: r = {1'b0, 5'd14};
      7'h71: r = {1'b0, 5'd15};
      7'h76: r = {1'b0, 5'd16};
      7'h37: r = {1'b0, 5'd17};
      7'h3E: r = {1'b0, 5'd18};
      7'h54: r = {1'b0, 5'd19};
      7'h31: r = {1'b0, 5'd20};
      7'h73: r = {1'b0, 5'd21};
      7'h38: r = {1'b0, 5'd22};
      7'h3D: r = {1'b0, 5'd23};
      7'h6E: r = {1'b0, 5'd24};
      7'h00: r = {1'b0, 5'd30};
      default: r = {1'b1, 5'd31};
    endcase
    return r;
  endfunction

  // Two-flop synchronisers for the asynchronous bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      dig_s1 <= '0;
      dig_s2 <= '0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      dig_s1 <= dig_in;
      dig_s2 <= dig_s1;
    end
  end

  assign seg_cur    = (SEG_ACTIVE_LOW != 0) ? ~seg_s2 : seg_s2;
  assign dig_cur    = (DIG_ACTIVE_LOW != 0) ? ~dig_s2 : dig_s2;
  assign sample_cur = {dig_cur, seg_cur};

  // sample_prev always holds the pattern run_cnt is counting, so the
  // capture decodes it rather than the live sample, which may already
  // have moved on in the capture cycle.
  assign dig_prev = sample_prev[SW-1:7];
  assign seg_prev = sample_prev[6:0];
  assign dec      = decode_seg(seg_prev);

  // run_done stops a second capture once the counter passes or saturates
  // at STABLE_CYC while the same pattern keeps being held.
  assign capture = (run_cnt == 8'(STABLE_CYC)) && !run_done;

  // Stability tracking: count consecutive identical one-hot samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_prev <= '0;
      run_cnt     <= '0;
      run_done    <= 1'b0;
    end else begin
      sample_prev <= sample_cur;
      if (!$onehot(dig_cur)) begin
        run_cnt  <= '0;
        run_done <= 1'b0;
      end else if (sample_cur != sample_prev) begin
        run_cnt  <= 8'd1;
        run_done <= 1'b0;
      end else begin
        if (run_cnt != 8'hFF) begin
          run_cnt <= run_cnt + 8'd1;
        end
        run_done <= run_done | capture;
      end
    end
  end

  // Per-digit storage and frame completion tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codes       <= {DIGITS{5'd30}};
      bad         <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (capture) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (dig_prev[i]) begin
            codes[5*i +: 5] <= dec[4:0];
            bad[i]          <= dec[5];
          end
        end
        if ((seen | dig_prev) == {DIGITS{1'b1}}) begin
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen | dig_prev;
        end
      end
    end
  end

endmodule

// File: tb/tb_ss2b_scan.sv
// tb_ss2b_scan: randomized scoreboard bench for ss2b_scan.
//
// Two instances are driven from the same stimulus: one with active-high
// buses, one with both buses active-low and fed the inverted lines. Both
// must produce identical decoded results.
module tb_ss2b_scan;

  localparam int DIGITS = 4;
  localparam int ST     = 4;

  typedef struct {
    int          cyc;
    logic [19:0] codes;
    logic [3:0]  bad;
    logic        fv;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  dig_in;
  logic [6:0]  seg_in_n;
  logic [3:0]  dig_in_n;
  logic [19:0] codes_a, codes_b;
  logic [3:0]  bad_a, bad_b;
  logic        fv_a, fv_b;

  int tests    = 0;
  int failures = 0;
  int cyc      = 0;

  chk_t chk_q[$];
  int   frame_qa[$];
  int   frame_qb[$];

  // Reference model state
  logic [4:0] m_code[4];
  logic       m_bad[4];
  logic [3:0] m_seen;
  logic [3:0] last_dig;
  logic [6:0] last_seg;

  logic [6:0] pats[25] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                           7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E,
                           7'h79, 7'h71, 7'h76, 7'h37, 7'h3E, 7'h54, 7'h31,
                           7'h73, 7'h38, 7'h3D, 7'h6E};

  assign seg_in_n = ~seg_in;
  assign dig_in_n = ~dig_in;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ss2b_scan #(.DIGITS(DIGITS), .STABLE_CYC(ST), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_in(dig_in),
    .codes(codes_a), .bad(bad_a), .frame_valid(fv_a)
  );

  ss2b_scan #(.DIGITS(DIGITS), .STABLE_CYC(ST), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .seg_in(seg_in_n), .dig_in(dig_in_n),
    .codes(codes_b), .bad(bad_b), .frame_valid(fv_b)
  );

  function automatic void ref_decode(input logic [6:0] s, output logic [4:0] code, output logic b);
    code = 5'd31;
    b    = 1'b1;
    if (s == 7'h00) begin
      code = 5'd30;
      b    = 1'b0;
    end
    for (int i = 0; i < 25; i++) begin
      if (pats[i] == s) begin
        code = 5'(i);
        b    = 1'b0;
      end
    end
  endfunction

  function automatic chk_t snapshot(input int at, input logic fv);
    chk_t c;
    c.cyc = at;
    c.fv  = fv;
    for (int i = 0; i < 4; i++) begin
      c.codes[5*i +: 5] = m_code[i];
      c.bad[i]          = m_bad[i];
    end
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_code[i] = 5'd30;
      m_bad[i]  = 1'b0;
    end
    m_seen   = 4'd0;
    last_dig = 4'd0;
    last_seg = 7'd0;
  endfunction

  // Hold one bus pattern for n clock edges and predict its effect.
  // A one-hot pattern held at least ST edges is captured, showing up
  // on the outputs ST+3 cycles after it was applied.
  task automatic applyStimulus(input logic [3:0] d, input logic [6:0] s, input int n);
    int         e;
    logic       fr;
    logic [4:0] code;
    logic       b;
    e  = cyc;
    fr = 1'b0;
    if ($countones(d) == 1 && n >= ST) begin
      ref_decode(s, code, b);
      for (int i = 0; i < 4; i++) begin
        if (d[i]) begin
          m_code[i] = code;
          m_bad[i]  = b;
        end
      end
      m_seen = m_seen | d;
      if (m_seen == 4'hF) begin
        fr     = 1'b1;
        m_seen = 4'd0;
        frame_qa.push_back(e + ST + 3);
        frame_qb.push_back(e + ST + 3);
      end
    end
    chk_q.push_back(snapshot(e + ST + 3, fr));
    dig_in   = d;
    seg_in   = s;
    last_dig = d;
    last_seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus(4'd0, 7'h00, 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_q.push_back(snapshot(cyc + 1, 1'b0));
  endtask

  task automatic checkOutput(input string name, input logic [19:0] cv, input logic [3:0] bv,
                             input logic fv, input chk_t c);
    tests++;
    if (cv !== c.codes || bv !== c.bad || fv !== c.fv) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got codes=%h bad=%b fv=%b expected codes=%h bad=%b fv=%b",
               name, cyc, cv, bv, fv, c.codes, c.bad, c.fv);
    end
  endtask

  // Monitor: pops checkpoints when due and matches every frame pulse
  // against the queue of predicted frame completions.
  initial begin
    chk_t c;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
        c = chk_q.pop_front();
        if (c.cyc < cyc) begin
          tests++;
          failures++;
          $display("[TB] FAIL missed_check cyc=%0d due=%0d", cyc, c.cyc);
        end else begin
          checkOutput("state_a", codes_a, bad_a, fv_a, c);
          checkOutput("state_b", codes_b, bad_b, fv_b, c);
        end
      end
      if (fv_a === 1'b1) begin
        tests++;
        if (frame_qa.size() > 0 && frame_qa[0] == cyc) begin
          void'(frame_qa.pop_front());
        end else begin
          failures++;
          $display("[TB] FAIL frame_a unexpected pulse cyc=%0d expected none", cyc);
        end
      end
      while (frame_qa.size() > 0 && frame_qa[0] <= cyc) begin
        tests++;
        failures++;
        $display("[TB] FAIL frame_a missing pulse cyc=%0d expected at %0d", cyc, frame_qa[0]);
        void'(frame_qa.pop_front());
      end
      if (fv_b === 1'b1) begin
        tests++;
        if (frame_qb.size() > 0 && frame_qb[0] == cyc) begin
          void'(frame_qb.pop_front());
        end else begin
          failures++;
          $display("[TB] FAIL frame_b unexpected pulse cyc=%0d expected none", cyc);
        end
      end
      while (frame_qb.size() > 0 && frame_qb[0] <= cyc) begin
        tests++;
        failures++;
        $display("[TB] FAIL frame_b missing pulse cyc=%0d expected at %0d", cyc, frame_qb[0]);
        void'(frame_qb.pop_front());
      end
    end
  end

  // Watchdog so the bench never hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout cyc=%0d expected finish", cyc);
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios followed by randomized bus traffic.
  initial begin
    logic [3:0] d;
    logic [6:0] s;
    int         n;
    int         r;
    rst    = 1'b1;
    dig_in = 4'd0;
    seg_in = 7'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_q.push_back(snapshot(cyc + 1, 1'b0));

    applyStimulus(4'd0, 7'h00, 10);
    applyStimulus(4'b0001, 7'h06, 10);
    applyStimulus(4'b0010, 7'h5B, 10);
    applyStimulus(4'b0100, 7'h4F, 10);
    applyStimulus(4'b1000, 7'h66, 10);

    applyStimulus(4'b0001, 7'h06, 5);
    applyStimulus(4'b0001, 7'h7F, 3);
    applyStimulus(4'd0, 7'h00, 10);

    applyStimulus(4'b0100, 7'h7E, 10);
    applyStimulus(4'b0100, 7'h3F, 10);

    applyStimulus(4'b0011, 7'h7F, 20);
    applyStimulus(4'b0000, 7'h7F, 20);

    applyStimulus(4'b0001, 7'h3F, 8);
    applyStimulus(4'b0010, 7'h06, 8);
    applyStimulus(4'b0100, 7'h5B, 8);
    doReset();
    applyStimulus(4'b0001, 7'h7D, 8);
    applyStimulus(4'b0010, 7'h6E, 8);
    applyStimulus(4'b0100, 7'h00, 8);
    applyStimulus(4'b1000, 7'h76, 8);

    for (int k = 0; k < 160; k++) begin
      if (k == 80) doReset();
      r = int'($urandom % 10);
      if (r < 7) d = 4'(1 << ($urandom % 4));
      else if (r == 7) d = 4'd0;
      else d = 4'($urandom);
      do begin
        if ($urandom % 4 == 0) s = 7'($urandom);
        else if ($urandom % 8 == 0) s = 7'h00;
        else s = pats[$urandom % 25];
      end while ($countones(d) == 1 && d == last_dig && s == last_seg);
      n = int'($urandom_range(1, 9));
      applyStimulus(d, s, n);
    end

    applyStimulus(4'd0, 7'h00, 12);
    repeat (5) @(negedge clk);
    tests++;
    if (chk_q.size() != 0 || frame_qa.size() != 0 || frame_qb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d/%0d/%0d expected 0/0/0",
               chk_q.size(), frame_qa.size(), frame_qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
